// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        count_q;
  logic                 isDiv_q;
  logic                 sa_q;
  logic                 sb_q;
  logic                 bZero_q;
  logic [WIDTH-1:0]     opB_q;
  logic [WIDTH-1:0]     aOrig_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;
  logic [WIDTH:0]       mulSum;
  logic [WIDTH+1:0]     divDiff;
  logic [2*WIDTH-1:0]   prodRes;
  logic [WIDTH-1:0]     quotRes;
  logic [WIDTH-1:0]     remRes;

  // op[0]==0 selects the signed variants; the most negative value keeps its
  // own bit pattern as magnitude, which is correct when read as unsigned.
  always_comb begin
    absA    = (!op[0] && a[WIDTH-1]) ? -a : a;
    absB    = (!op[0] && b[WIDTH-1]) ? -b : b;
    mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
    divDiff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opB_q};
    if (isDiv_q) begin
      acc_d = divDiff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mulSum, acc_q[WIDTH-1:1]};
    end
    prodRes = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quotRes = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remRes  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      isDiv_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bZero_q <= 1'b0;
      opB_q   <= '0;
      aOrig_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            isDiv_q <= op[1];
            sa_q    <= !op[0] && a[WIDTH-1];
            sb_q    <= !op[0] && b[WIDTH-1];
            bZero_q <= (b == '0);
            opB_q   <= absB;
            aOrig_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, absA};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            if (hi_we) hi_q <= wd;
            if (lo_we) lo_q <= wd;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          // A zero divisor returns all-ones quotient and the untouched dividend.
          if (isDiv_q && bZero_q) begin
            hi_q <= aOrig_q;
            lo_q <= '1;
          end else if (isDiv_q) begin
            hi_q <= remRes;
            lo_q <= quotRes;
          end else begin
            hi_q <= prodRes[2*WIDTH-1:WIDTH];
            lo_q <= prodRes[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a high-level arithmetic model predicts HI/LO,
// and a monitor compares them whenever done pulses.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sbQueue[$];
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic in plain 64-bit integers; division truncates toward zero.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {32'(x % y), 32'(x / y)};
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && done === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=done expected=no_pending_op");
      end else begin
        e = sbQueue.pop_front();
        checkOutput("result_hi", 64'(hi), 64'(e[63:32]));
        checkOutput("result_lo", 64'(lo), 64'(e[31:0]));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input int injectAt, input int resetAt, input logic loWrite);
    int          n;
    int          doneCount;
    bit          seenDone, holdOk, busyOk;
    logic [31:0] prevHi, prevLo;
    logic [63:0] exp;
    prevHi = modelHi;
    prevLo = modelLo;
    exp    = refModel(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (loWrite) begin
      lo_we = 1'b1;
      wd    = 32'h5A5A_A5A5;
    end
    if (resetAt == 0) sbQueue.push_back(exp);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    n = 1; seenDone = 0; holdOk = 1; busyOk = 1;
    while (!seenDone && n <= 100) begin
      if (resetAt != 0 && n == resetAt) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        doneCount = 0;
        repeat (40) begin
          @(negedge clk);
          if (done === 1'b1) doneCount++;
        end
        checkOutput("reset_no_done", 64'(doneCount), 64'd0);
        modelHi = '0;
        modelLo = '0;
        return;
      end
      if (done === 1'b1) begin
        seenDone = 1;
      end else begin
        if (busy !== 1'b1) busyOk = 0;
        if (hi !== prevHi || lo !== prevLo) holdOk = 0;
        if (n == injectAt) begin
          start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
          hi_we = 1'b1; wd = $urandom;
        end else begin
          start = 1'b0; hi_we = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    // done appears in the 34th cycle after the start edge
    checkOutput("done_latency", 64'(n), 64'd34);
    checkOutput("busy_while_calc", 64'(busyOk), 64'd1);
    checkOutput("hilo_hold", 64'(holdOk), 64'd1);
    if (seenDone) begin
      modelHi = exp[63:32];
      modelLo = exp[31:0];
    end else begin
      void'(sbQueue.pop_back());
    end
  endtask

  task automatic idleWrite(input logic hw, input logic lw, input logic [31:0] data);
    @(negedge clk);
    hi_we = hw; lo_we = lw; wd = data;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) modelHi = data;
    if (lw) modelLo = data;
    checkOutput("idle_write_hi", 64'(hi), 64'(modelHi));
    checkOutput("idle_write_lo", 64'(lo), 64'(modelLo));
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wd = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state_hi", 64'(hi), 64'd0);
    checkOutput("reset_state_lo", 64'(lo), 64'd0);
    checkOutput("reset_state_busy", 64'(busy), 64'd0);
    checkOutput("reset_state_done", 64'(done), 64'd0);
    rst = 1'b0;

    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    applyStimulus(2'b11, 32'd100, 32'd7, 0, 0, 1'b0);
    applyStimulus(2'b11, 32'h1234_5678, 32'h0, 0, 0, 1'b0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    applyStimulus(2'b10, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);

    idleWrite(1'b1, 1'b0, 32'hAAAA_5555);
    idleWrite(1'b1, 1'b1, 32'h0F0F_1234);

    applyStimulus(2'b11, 32'd100, 32'd7, 0, 0, 1'b1);
    applyStimulus(2'b01, 32'd3, 32'd4, 10, 0, 1'b0);
    applyStimulus(2'b01, 32'd3, 32'd4, 0, 20, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(), 0, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sbQueue.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
